wsel_decoder: RTL and testbench
===============================

Name: wsel_decoder

Overview:
- Registered, parametrised ADDR_W-to-2^ADDR_W one-hot write-select generator for the register-file write port of the datapath.
- Normal mode: decodes a write address into a registered one-hot enable.
- Clear mode: a sweep sequencer walks a one-hot enable across every register, so the register file can zero itself after reset or on command, with busy/done status.

Parameters:
- ADDR_W, 4, address width; number of selects NREG = 2^ADDR_W (derived, not overridable).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- we  input  1  write request, sampled each rising edge
- waddr  input  ADDR_W  register address for we
- clr_start  input  1  request a full clear sweep (level sampled; only acted on in IDLE)
- sel  output  NREG  registered one-hot (or all-zero) write enable
- busy  output  1  high while the sweep is in progress, including the DONE cycle
- done  output  1  one-cycle pulse marking the end of a sweep
- drop  output  1  one-cycle pulse: a we request was discarded

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, sel=0, busy=0, done=0, drop=0. Applies immediately, including mid-sweep; the sweep is abandoned, not resumed.
- All outputs are registered. sel is never more than one-hot.
- The state machine has three states: IDLE, SWEEP, DONE.
- IDLE, clr_start=0:
  - sel <= we ? (1 << waddr) : 0
  - Latency is one cycle: request at edge k, enable visible after edge k.
- IDLE, clr_start=1:
  - Go to SWEEP; sel <= 1<<0; cnt <= 1; busy <= 1.
  - If we=1 in the same cycle, the write is discarded and drop <= 1 (clear wins).
- SWEEP:
  - sel <= 1<<cnt; cnt <= cnt+1.
  - When sel already holds bit NREG-1: sel <= 0, done <= 1, go to DONE.
  - sel therefore shows NREG consecutive one-hot values, 0..NREG-1, ascending.
- DONE: one cycle; busy stays 1, done=1; next edge returns to IDLE with busy <= 0, done <= 0.
- In SWEEP or DONE:
  - we=1 is discarded and drop pulses the next cycle.
  - clr_start is ignored; no restart and no queueing.
- cnt is ADDR_W bits wide. Wrap from NREG-1 to 0 is never used to index sel; the terminal check is on sel bit NREG-1.
- In IDLE, consecutive we cycles produce back-to-back selects with no bubble.
- drop is a pulse per discarded request and is not sticky.
- ADDR_W=1 is legal: the sweep is 2 cycles, followed by DONE.

Optional Feature:
- Macro: WSEL_R0_PROTECT_EN.
- Defined:
  - Register 0 is hardwired read-only in normal mode. A we to waddr=0 in IDLE yields sel=0 and drop pulses.
  - The sweep still asserts sel[0], because clearing R0 is harmless.
- Undefined: address 0 is treated like every other address.

Decomposition:
- Shared package wsel_pkg holds:
  - the state enum (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2)
  - the onehot function (address -> NREG-bit vector)
- One natural sub-module: onehot_dec. It is a purely combinational parametrised ADDR_W-to-NREG decoder with an enable input, instantiated once on the muxed address (waddr or cnt).
- wsel_decoder contains the FSM, cnt, and output registers.

Test Plan (all at ADDR_W=4):
- Reset then idle: rst pulse asserted mid-clock -> sel=16'h0000, busy=0, done=0, drop=0 immediately, before any clock edge.
- Normal decode: we=1, waddr=4'hA at edge k -> sel=16'h0400 after edge k; we=0 next cycle -> sel=16'h0000. Back-to-back waddr 3 then 15 -> 16'h0008 then 16'h8000.
- Full sweep: clr_start=1 for one cycle -> sel=16'h0001,16'h0002,...,16'h8000 on 16 consecutive cycles, then sel=0 with done=1 and busy=1 for one cycle, then busy=0.
- Collision: we=1, waddr=5 with clr_start=1 in IDLE -> sweep starts with sel=16'h0001 and drop=1. A we during the sweep at step 7 -> drop pulse, sweep sequence unaltered. A clr_start during the sweep -> no restart.
- Reset mid-sweep: rst asserted while sel=16'h0040 -> sel=0 and busy=0 at once. After release, we=1, waddr=2 -> sel=16'h0004.
- WSEL_R0_PROTECT_EN defined: we=1, waddr=0 -> sel=0, drop=1. A sweep still emits 16'h0001 first. With the macro undefined, the same write -> sel=16'h0001, drop=0.

Source files
------------

// File: rtl/wsel_pkg.sv
// Shared types and helpers for the register-file write-select generator.
// Supports address widths up to MAX_ADDR_W.
package wsel_pkg;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_NREG   = 1 << MAX_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } wsel_state_e;

  function automatic logic [MAX_NREG-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr);
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/wsel_decoder_onehot_dec.sv
// Combinational ADDR_W-to-NREG one-hot decoder with enable; all-zero when disabled.
module onehot_dec
  import wsel_pkg::*;
#(
  parameter  int ADDR_W = 4,
  localparam int NREG   = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [NREG-1:0]   onehot_o
);

  logic [MAX_NREG-1:0] full;

  assign full     = onehot(MAX_ADDR_W'(addr_i));
  assign onehot_o = en_i ? full[NREG-1:0] : '0;

  if (NREG < MAX_NREG) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^full[MAX_NREG-1:NREG];
  end

endmodule

// File: rtl/wsel_decoder.sv
// Registered one-hot write-select generator with a clear-sweep sequencer.
// Optional: WSEL_R0_PROTECT_EN makes register 0 read-only in normal mode.
//
// state | meaning
// IDLE  | normal decode of we/waddr
// SWEEP | walking one-hot enable across all registers
// DONE  | one-cycle end-of-sweep marker, busy still high
module wsel_decoder
  import wsel_pkg::*;
#(
  parameter  int ADDR_W = 4,
  localparam int NREG   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              clr_start,
  output logic [NREG-1:0]   sel,
  output logic              busy,
  output logic              done,
  output logic              drop
);

  wsel_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]   sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  logic [ADDR_W-1:0] dec_addr;
  logic              dec_en;
  logic [NREG-1:0]   dec_sel;
  logic              r0_hit;
  logic              last;

`ifdef WSEL_R0_PROTECT_EN
  assign r0_hit = (waddr == '0);
`else
  assign r0_hit = 1'b0;
`endif

  // Terminal check is on the emitted select, not on cnt, which wraps.
  assign last = sel_q[NREG-1];

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
    .addr_i   (dec_addr),
    .en_i     (dec_en),
    .onehot_o (dec_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_start) state_d = SWEEP;
      SWEEP:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    dec_addr = cnt_q;
    dec_en   = 1'b0;
    drop_d   = we;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          dec_addr = '0;
          dec_en   = 1'b1;
          cnt_d    = ADDR_W'(1);
        end else begin
          dec_addr = waddr;
          dec_en   = we & ~r0_hit;
          drop_d   = we & r0_hit;
        end
      end
      SWEEP: begin
        dec_en = ~last;
        cnt_d  = last ? '0 : cnt_q + ADDR_W'(1);
      end
      default: ;
    endcase
    sel_d  = dec_sel;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_wsel_decoder.sv
// Self-checking bench for wsel_decoder at ADDR_W=4 against a phase-based reference model.
module tb_wsel_decoder;

`ifdef WSEL_R0_PROTECT_EN
  localparam bit R0P = 1'b1;
`else
  localparam bit R0P = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic        clr_start = 1'b0;
  logic [15:0] sel;
  logic        busy, done, drop;

  int n_chk = 0;
  int n_fail = 0;

  // phase 0 = idle, 1..16 = sweep showing bit phase-1, 17 = done
  int          m_phase = 0;
  logic [15:0] exp_sel = '0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_drop = 1'b0;

  wsel_decoder #(.ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .clr_start (clr_start),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int          np;
    logic [15:0] ns;
    logic        nd;
    logic        prot;
    prot = R0P && (waddr == 4'd0);
    ns = '0;
    nd = we;
    if (m_phase == 0) begin
      if (clr_start) np = 1;
      else begin
        np = 0;
        nd = we && prot;
        if (we && !prot) ns = 16'(1) << waddr;
      end
    end else if (m_phase <= 16) np = m_phase + 1;
    else np = 0;
    if (np >= 1 && np <= 16) ns = 16'(1) << (np - 1);
    @(posedge clk);
    #1;
    m_phase  = np;
    exp_sel  = ns;
    exp_busy = (np != 0);
    exp_done = (np == 17);
    exp_drop = nd;
  endtask

  task automatic model_reset();
    m_phase  = 0;
    exp_sel  = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_drop = 1'b0;
  endtask

  task automatic test_reset();
    we = 1'b1; waddr = 4'd3;
    tick();
    we = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_chk++; if (sel !== 16'h0000) begin n_fail++; $display("FAIL reset_sel got=%h exp=0000", sel); end
    n_chk++; if ({busy, done, drop} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, done, drop}); end
    #3 rst = 1'b0;
  endtask

  task automatic test_normal_decode();
    we = 1'b1; waddr = 4'hA;
    tick();
    n_chk++; if (sel !== 16'h0400) begin n_fail++; $display("FAIL norm_A got=%h exp=0400", sel); end
    n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL norm_A_drop got=%b exp=0", drop); end
    we = 1'b0;
    tick();
    n_chk++; if (sel !== 16'h0000) begin n_fail++; $display("FAIL norm_idle got=%h exp=0000", sel); end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; waddr = 4'd3;
    tick();
    n_chk++; if (sel !== 16'h0008) begin n_fail++; $display("FAIL b2b_3 got=%h exp=0008", sel); end
    waddr = 4'd15;
    tick();
    n_chk++; if (sel !== 16'h8000) begin n_fail++; $display("FAIL b2b_15 got=%h exp=8000", sel); end
    we = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n_chk++; if (sel !== 16'h0001 || busy !== 1'b1) begin n_fail++; $display("FAIL sweep_first sel=%h busy=%b exp=0001/1", sel, busy); end
    for (int i = 1; i < 16; i++) begin
      tick();
      n_chk++;
      if (sel !== (16'(1) << i) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL sweep_step%0d sel=%h busy=%b done=%b exp=%h/1/0", i, sel, busy, done, 16'(1) << i);
      end
    end
    tick();
    n_chk++; if (sel !== 16'h0000 || done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL sweep_done sel=%h done=%b busy=%b exp=0000/1/1", sel, done, busy); end
    tick();
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL sweep_exit busy=%b done=%b exp=0/0", busy, done); end
  endtask

  task automatic test_collision();
    we = 1'b1; waddr = 4'd5; clr_start = 1'b1;
    tick();
    we = 1'b0; clr_start = 1'b0;
    n_chk++; if (sel !== 16'h0001 || drop !== 1'b1) begin n_fail++; $display("FAIL coll_start sel=%h drop=%b exp=0001/1", sel, drop); end
    for (int i = 1; i <= 18; i++) begin
      we = (i == 7);
      waddr = 4'd9;
      clr_start = (i == 10) || (i == 17);
      tick();
      n_chk++;
      if (sel !== exp_sel || busy !== exp_busy || done !== exp_done || drop !== exp_drop) begin
        n_fail++; $display("FAIL coll_step%0d sel=%h b=%b d=%b dr=%b exp=%h/%b/%b/%b", i, sel, busy, done, drop, exp_sel, exp_busy, exp_done, exp_drop);
      end
      if (i == 7) begin
        n_chk++; if (drop !== 1'b1 || sel !== 16'h0080) begin n_fail++; $display("FAIL coll_we_drop drop=%b sel=%h exp=1/0080", drop, sel); end
      end
    end
    we = 1'b0; clr_start = 1'b0;
    n_chk++; if (busy !== 1'b0 || sel !== 16'h0000) begin n_fail++; $display("FAIL coll_no_restart busy=%b sel=%h exp=0/0000", busy, sel); end
  endtask

  task automatic test_reset_mid_sweep();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (6) tick();
    n_chk++; if (sel !== 16'h0040) begin n_fail++; $display("FAIL rms_pre got=%h exp=0040", sel); end
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_chk++; if (sel !== 16'h0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rms_async sel=%h busy=%b exp=0000/0", sel, busy); end
    #2 rst = 1'b0;
    we = 1'b1; waddr = 4'd2;
    tick();
    n_chk++; if (sel !== 16'h0004 || busy !== 1'b0) begin n_fail++; $display("FAIL rms_after sel=%h busy=%b exp=0004/0", sel, busy); end
    we = 1'b0;
    tick();
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 4'd0;
    tick();
    we = 1'b0;
`ifdef WSEL_R0_PROTECT_EN
    n_chk++; if (sel !== 16'h0000 || drop !== 1'b1) begin n_fail++; $display("FAIL r0_write sel=%h drop=%b exp=0000/1", sel, drop); end
`else
    n_chk++; if (sel !== 16'h0001 || drop !== 1'b0) begin n_fail++; $display("FAIL r0_write sel=%h drop=%b exp=0001/0", sel, drop); end
`endif
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n_chk++; if (sel !== 16'h0001) begin n_fail++; $display("FAIL r0_sweep got=%h exp=0001", sel); end
    repeat (17) tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL r0_sweep_end busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we        = 1'($urandom_range(0, 1));
      waddr     = 4'($urandom_range(0, 15));
      clr_start = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_chk++; if (sel !== 16'h0000 || {busy, done, drop} !== 3'b000) begin n_fail++; $display("FAIL rnd_rst%0d sel=%h flags=%b exp=0000/000", c, sel, {busy, done, drop}); end
        #1 rst = 1'b0;
      end
      tick();
      n_chk++;
      if (sel !== exp_sel || busy !== exp_busy || done !== exp_done || drop !== exp_drop) begin
        n_fail++; $display("FAIL rnd%0d sel=%h b=%b d=%b dr=%b exp=%h/%b/%b/%b", c, sel, busy, done, drop, exp_sel, exp_busy, exp_done, exp_drop);
      end
      n_chk++; if (!$onehot0(sel)) begin n_fail++; $display("FAIL rnd_onehot%0d sel=%h exp=onehot0", c, sel); end
    end
    we = 1'b0; clr_start = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;
    model_reset();
    test_reset();
    test_normal_decode();
    test_back_to_back();
    test_full_sweep();
    test_collision();
    test_reset_mid_sweep();
    test_r0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
